// File: rtl/s_seq_packer.sv
// Packs a 2-bit nucleotide stream into PE-array-wide chunks and hands one chunk
// to the data processor per request, flagging the end of the S sequence.
module s_seq_packer #(
  parameter int PE_ARRAY_SIZE     = 16,
  parameter int PE_ARRAY_SIZE_LOG = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_clear,
  input  logic                           i_char_valid,
  input  logic [1:0]                     i_char,
  input  logic                           i_char_last,
  output logic                           o_char_ready,
  input  logic                           i_request_s,
  output logic [PE_ARRAY_SIZE*2-1:0]     o_s,
  output logic [PE_ARRAY_SIZE_LOG:0]     o_s_valid
);

  localparam int                CHUNK_W = PE_ARRAY_SIZE * 2;
  localparam int                CNT_W   = PE_ARRAY_SIZE_LOG + 1;
  localparam logic [CNT_W-1:0]  FULL    = CNT_W'(PE_ARRAY_SIZE);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    READY = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t               state_q;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [CHUNK_W-1:0]   chunk_q, chunk_d;
  logic                 pending_q;
  logic                 last_flag_q;
  logic                 char_ready_q;
  logic [CHUNK_W-1:0]   s_q;
  logic [CNT_W-1:0]     s_valid_q;

  logic                 accept;
  logic                 req_any;
  logic                 chunk_done;

  // char_ready_q is high only while in FILL, so it doubles as the acceptance gate
  assign accept     = i_char_valid & char_ready_q;
  assign req_any    = pending_q | i_request_s;
  assign count_d    = count_q + CNT_W'(1);
  assign chunk_done = (count_d == FULL) | i_char_last;

  always_comb begin
    chunk_d = chunk_q;
    for (int k = 0; k < PE_ARRAY_SIZE; k++) begin
      if (count_q == CNT_W'(k)) chunk_d[2*k +: 2] = i_char;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FILL;
      count_q      <= '0;
      chunk_q      <= '0;
      pending_q    <= 1'b0;
      last_flag_q  <= 1'b0;
      char_ready_q <= 1'b0;
      s_q          <= '0;
      s_valid_q    <= '0;
    end else if (i_clear) begin
      state_q      <= FILL;
      count_q      <= '0;
      chunk_q      <= '0;
      pending_q    <= 1'b0;
      last_flag_q  <= 1'b0;
      char_ready_q <= 1'b1;
      s_valid_q    <= '0;
    end else begin
      s_valid_q <= '0;
      case (state_q)
        FILL: begin
          pending_q    <= req_any;
          char_ready_q <= !(accept && chunk_done);
          if (accept) begin
            chunk_q <= chunk_d;
            count_q <= count_d;
            if (chunk_done) begin
              state_q     <= READY;
              last_flag_q <= i_char_last;
            end
          end
        end
        READY: begin
          if (req_any) begin
            s_q          <= chunk_q;
            s_valid_q    <= count_q;
            count_q      <= '0;
            chunk_q      <= '0;
            pending_q    <= 1'b0;
            last_flag_q  <= 1'b0;
            state_q      <= last_flag_q ? DONE : FILL;
            char_ready_q <= !last_flag_q;
          end else begin
            char_ready_q <= 1'b0;
          end
        end
        DONE: begin
          // exhausted: every request gets an empty response
          char_ready_q <= 1'b0;
          pending_q    <= 1'b0;
          if (req_any) s_q <= '0;
        end
        default: begin
          state_q      <= FILL;
          char_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_char_ready = char_ready_q;
  assign o_s          = s_q;
  assign o_s_valid    = s_valid_q;

endmodule

// File: doc/s_seq_packer.md
Name: s_seq_packer

Overview:
- Upstream feeder for the data processor's S-sequence port.
- Accepts the query sequence one 2-bit nucleotide per cycle from the top-level input stream.
- Packs characters into PE-array-wide chunks and returns one chunk per request from the data processor, together with a valid-character count.
- A final partial chunk, followed by an exhaustion indication, tells the data processor where the S sequence ends.

Parameters:
- PE_ARRAY_SIZE, 16, number of PEs; characters per chunk.
- PE_ARRAY_SIZE_LOG, 4, log2(PE_ARRAY_SIZE).

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  asynchronous reset, active low.
- i_clear  input  1  synchronous restart for a new sequence. Discards all held state and returns to FILL.
- i_char_valid  input  1  i_char is presented this cycle.
- i_char  input  2  nucleotide code.
- i_char_last  input  1  qualifies i_char_valid; this character ends the sequence.
- o_char_ready  output  1  the block accepts a character this cycle.
- i_request_s  input  1  single-cycle request for the next chunk (data processor o_request_s).
- o_s  output  PE_ARRAY_SIZE*2  packed chunk.
- o_s_valid  output  PE_ARRAY_SIZE_LOG+1  number of valid characters in o_s. Nonzero only in the response cycle.

Behaviour:
- Reset (rst_n low, async):
  - state=FILL, count=0, pending=0, o_s=0, o_s_valid=0.
  - o_char_ready=1 one cycle after reset release. Registered output, 0 while in reset.
- Character acceptance: a character is accepted when i_char_valid && o_char_ready. o_char_ready is registered and equals (state==FILL).
- Packing: character k of a chunk (k=0 first) occupies o_s bits [2k+1:2k]. Unfilled upper positions of a partial chunk read 0.
- FILL -> READY in the cycle after acceptance when either condition holds:
  - count reaches PE_ARRAY_SIZE, or
  - i_char_last is accepted. last_flag is set on this path.
- If both conditions occur on the same character (full chunk ending on last), the chunk holds count=PE_ARRAY_SIZE and last_flag=1.
- o_char_ready drops in the same cycle the state enters READY. At most one extra character can be offered; it is not accepted and the source must hold it.
- Request handling:
  - i_request_s in any state sets pending.
  - Requests while pending is already set are absorbed: at most one outstanding request.
- READY with pending (or i_request_s this cycle):
  - Next cycle: o_s = packed chunk, o_s_valid = count, for exactly one cycle.
  - Then count=0, pending=0, state -> FILL, or -> DONE if last_flag.
- Latency:
  - Request in READY at cycle t gives the response at t+1.
  - If the chunk completes at cycle t with a request already pending, the response comes at t+2.
- DONE:
  - o_char_ready=0; characters are ignored.
  - Each request is answered next cycle by a one-cycle pulse with o_s_valid=0 and o_s=0 (sequence exhausted).
- o_s holds its last value between responses, except in DONE responses, where it is 0. o_s_valid returns to 0 after every response cycle.
- i_clear: takes priority over all other events in its cycle. Next cycle: FILL, count=0, pending=0, last_flag=0, o_s_valid=0.
- A request arriving in the same cycle the chunk completes is pended, not lost.
- Reset mid-chunk discards the partial chunk.
- count is PE_ARRAY_SIZE_LOG+1 bits and never wraps. FILL exits at PE_ARRAY_SIZE.

Test Plan:
- Basic full chunk (N=16):
  - Stimulus: reset; feed 16 chars 0,1,2,3 repeating with no last; request 2 cycles later.
  - Required: one cycle with o_s=32'hE4E4E4E4, o_s_valid=16; o_char_ready=1 again the following cycle.
- Partial final chunk:
  - Stimulus: feed 5 chars all 2'b11 with last on the 5th; request.
  - Required: o_s=32'h000003FF, o_s_valid=5. A second request gives o_s_valid=0, o_s=0; o_char_ready stays 0.
- Early request:
  - Stimulus: request while count=3, then feed 13 more chars.
  - Required: response appears exactly 2 cycles after the 16th acceptance with o_s_valid=16. No response before that.
- Full chunk ending on last:
  - Stimulus: 16 chars with last on the 16th; two requests.
  - Required: first response o_s_valid=16; second response o_s_valid=0.
- Backpressure:
  - Stimulus: hold i_char_valid high continuously.
  - Required: exactly 16 accepted per chunk; the 17th char is accepted only after that chunk's response cycle.
- Clear and reset:
  - Stimulus (clear): assert i_clear in DONE; a new 3-char sequence with last, then request. Required: o_s_valid=3.
  - Stimulus (reset): async rst_n low mid-fill. Required: all outputs 0 immediately; the partial chunk is never emitted.
